// File: rtl/mem_pkg.sv
// Shared encodings and store-lane helpers for the memory access stage.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] dat);
    case (size)
      SZ_BYTE: return {4{dat[7:0]}};
      SZ_HALF: return {2{dat[15:0]}};
      default: return dat;
    endcase
  endfunction

  // Encoding 11 behaves as a word everywhere.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension (byte, half, word).
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// M stage: load/store to a req/ready memory port, 3 cycles at zero wait, stalls while BUSY.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses without issuing a request.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        validM,
  input  logic        regWriteM,
  input  logic        memToRegM,
  input  logic        memWriteM,
  input  logic [1:0]  memSizeM,
  input  logic        memSignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] writeDataM,
  input  logic [31:0] memRdata,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  output logic [31:0] readDataM,
  output logic        regWriteOutM,
  output logic        stallM,
  output logic        busErrM,
  output logic        alignErrM
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_rdata;
  logic          r_bus_err;
  logic          r_is_load;
  logic          r_signed;
  logic [1:0]    r_size;
  logic [1:0]    r_lo;

  logic          w_access;
  logic          w_misalign;
  logic          w_launch;
  logic [31:0]   w_load_dat;

  assign w_access = validM & (memToRegM | memWriteM);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access & is_misaligned(memSizeM, ALUOutM[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_launch = (r_state == ST_IDLE) & w_access & ~w_misalign;

  load_align u_load_align (
    .i_rdata  (memRdata),
    .i_lo     (r_lo),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_load_dat)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
      r_is_load <= 1'b0;
      r_signed  <= 1'b0;
      r_size    <= SZ_BYTE;
      r_lo      <= 2'b00;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state   <= ST_BUSY;
            r_cnt     <= '0;
            r_req     <= 1'b1;
            r_we      <= memWriteM;
            r_addr    <= {ALUOutM[31:2], 2'b00};
            r_wdata   <= store_lanes(memSizeM, writeDataM);
            r_be      <= memWriteM ? store_be(memSizeM, ALUOutM[1:0]) : 4'b1111;
            r_is_load <= memToRegM;
            r_signed  <= memSignedM;
            r_size    <= memSizeM;
            r_lo      <= ALUOutM[1:0];
          end
        end
        ST_BUSY: begin
          // A ready arriving on the limit cycle still wins over the timeout.
          if (memReady) begin
            r_state <= ST_DONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            if (r_is_load) r_rdata <= w_load_dat;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
              r_state   <= ST_DONE;
              r_req     <= 1'b0;
              r_we      <= 1'b0;
              r_bus_err <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign memReq       = r_req;
  assign memWe        = r_we;
  assign memAddr      = r_addr;
  assign memWdata     = r_wdata;
  assign memBe        = r_be;
  assign readDataM    = r_rdata;
  assign busErrM      = r_bus_err;
  assign alignErrM    = w_misalign & (r_state == ST_IDLE);
  assign stallM       = rstN & (w_launch | (r_state == ST_BUSY));
  assign regWriteOutM = regWriteM & validM & ~r_bus_err & ~w_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed table-driven bench for mem_access_stage with TIMEOUT_CYCLES = 4.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        validM, regWriteM, memToRegM, memWriteM, memSignedM, memReady;
  logic [1:0]  memSizeM;
  logic [31:0] ALUOutM, writeDataM, memRdata;
  logic        memReq, memWe, regWriteOutM, stallM, busErrM, alignErrM;
  logic [31:0] memAddr, memWdata, readDataM;
  logic [3:0]  memBe;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstN(rstN), .validM(validM), .regWriteM(regWriteM),
    .memToRegM(memToRegM), .memWriteM(memWriteM), .memSizeM(memSizeM),
    .memSignedM(memSignedM), .ALUOutM(ALUOutM), .writeDataM(writeDataM),
    .memRdata(memRdata), .memReady(memReady), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe), .readDataM(readDataM),
    .regWriteOutM(regWriteOutM), .stallM(stallM), .busErrM(busErrM), .alignErrM(alignErrM)
  );

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] dat;
    int          waits;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bubble();
    validM = 1'b0; regWriteM = 1'b0; memToRegM = 1'b0; memWriteM = 1'b0;
    memSizeM = 2'b00; memSignedM = 1'b0; ALUOutM = 32'h0; writeDataM = 32'h0;
    memRdata = 32'h0; memReady = 1'b0;
  endtask

  task automatic run_access(input vec_t v, input string tag);
    int          stalls = 0, reqs = 0, wes = 0;
    bit          unstable = 0, done = 0, aerr = 0;
    logic [31:0] a = 32'h0, wd = 32'h0, rd = 32'h0;
    logic [3:0]  be = 4'h0;
    logic        rwo = 1'b0;
    validM = 1'b1; regWriteM = ~v.st; memToRegM = ~v.st; memWriteM = v.st;
    memSizeM = v.sz; memSignedM = v.sgn; ALUOutM = v.addr;
    writeDataM = v.st ? v.dat : 32'h0; memRdata = 32'h0; memReady = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (alignErrM) aerr = 1;
      if (!stallM) begin
        done = 1; rd = readDataM; rwo = regWriteOutM;
      end else begin
        stalls++;
        if (memReq) begin
          if (reqs == 0) begin a = memAddr; be = memBe; wd = memWdata; end
          else if (memAddr !== a || memBe !== be || memWdata !== wd) unstable = 1;
          reqs++;
          if (memWe) wes++;
          if (reqs == v.waits + 1) begin
            memReady = 1'b1;
            memRdata = v.st ? 32'h0 : v.dat;
          end
        end
      end
      @(posedge clk); #1;
      memReady = 1'b0; memRdata = 32'h0;
    end
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " memAddr"}, a, v.e_addr);
    chk({tag, " memBe"}, 32'(be), 32'(v.e_be));
    if (v.st) chk({tag, " memWdata"}, wd, v.e_wdata);
    chk({tag, " readDataM"}, rd, v.e_rdata);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(v.waits + 2));
    chk({tag, " req cycles"}, 32'(reqs), 32'(v.waits + 1));
    chk({tag, " we cycles"}, 32'(wes), v.st ? 32'(v.waits + 1) : 32'd0);
    chk({tag, " stable in BUSY"}, 32'(unstable), 32'd0);
    chk({tag, " regWriteOutM"}, 32'(rwo), v.st ? 32'd0 : 32'd1);
    chk({tag, " alignErrM"}, 32'(aerr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_last;
    int          stalls, reqs;
    bit          done;
    logic        be_seen, rwo_seen;

    //          st   sz     sgn  addr          dat           w  e_addr        e_wdata       e_be     e_rdata
    tbl[0] = '{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h80FF_FF00, 0, 32'h0000_1000, 32'h0,        4'b1111, 32'hFFFF_FF80};
    tbl[1] = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h80FF_FF00, 1, 32'h0000_1000, 32'h0,        4'b1111, 32'h0000_0080};
    tbl[2] = '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h8001_7FFF, 0, 32'h0000_2000, 32'h0,        4'b1111, 32'hFFFF_8001};
    tbl[3] = '{1'b0, 2'b01, 1'b1, 32'h0000_2000, 32'h8001_F234, 2, 32'h0000_2000, 32'h0,        4'b1111, 32'hFFFF_F234};
    tbl[4] = '{1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h1122_3344, 0, 32'h0000_1000, 32'h0,        4'b1111, 32'h0000_0033};
    tbl[5] = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 32'h0000_0033};
    tbl[6] = '{1'b1, 2'b00, 1'b0, 32'h0000_4001, 32'hFFFF_FF5A, 0, 32'h0000_4000, 32'h5A5A_5A5A, 4'b0010, 32'h0000_0033};
    tbl[7] = '{1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 1, 32'h0000_5004, 32'hCAFE_F00D, 4'b1111, 32'h0000_0033};
    tbl[8] = '{1'b1, 2'b01, 1'b0, 32'h0000_2000, 32'h0000_7777, 0, 32'h0000_2000, 32'h7777_7777, 4'b0011, 32'h0000_0033};
    tbl[9] = '{1'b0, 2'b10, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 0, 32'h0000_3000, 32'h0,        4'b1111, 32'hDEAD_BEEF};

    rstN = 1'b0;
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset memReq", 32'(memReq), 32'd0);
    chk("reset memWe", 32'(memWe), 32'd0);
    chk("reset memAddr", memAddr, 32'h0);
    chk("reset memWdata", memWdata, 32'h0);
    chk("reset memBe", 32'(memBe), 32'd0);
    chk("reset readDataM", readDataM, 32'h0);
    chk("reset busErrM", 32'(busErrM), 32'd0);
    chk("reset alignErrM", 32'(alignErrM), 32'd0);
    chk("reset stallM", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;

    for (int i = 0; i < 10; i++) run_access(tbl[i], $sformatf("vec%0d", i));
    exp_last = tbl[9].e_rdata;

`ifndef MEM_ALIGN_CHECK_EN
    run_access('{1'b0, 2'b10, 1'b0, 32'h0000_7001, 32'h0102_0304, 0, 32'h0000_7000, 32'h0,
                 4'b1111, 32'h0102_0304}, "lw_unaligned_ignored");
    run_access('{1'b1, 2'b01, 1'b0, 32'h0000_2003, 32'h0000_BEEF, 1, 32'h0000_2000, 32'hBEEF_BEEF,
                 4'b1100, 32'h0102_0304}, "sh_odd_ignored");
    exp_last = 32'h0102_0304;
`endif

    // Non-memory instruction right after a completed load.
    bubble();
    validM = 1'b1; regWriteM = 1'b1;
    @(negedge clk);
    chk("add stallM", 32'(stallM), 32'd0);
    chk("add regWriteOutM", 32'(regWriteOutM), 32'd1);
    chk("add memReq", 32'(memReq), 32'd0);
    chk("add readDataM held", readDataM, exp_last);
    @(posedge clk); #1;
    validM = 1'b0;
    @(negedge clk);
    chk("bubble regWriteOutM", 32'(regWriteOutM), 32'd0);
    @(posedge clk); #1;

    // Timeout: memReady never arrives.
    validM = 1'b1; regWriteM = 1'b1; memToRegM = 1'b1; memSizeM = 2'b10; ALUOutM = 32'h0000_6000;
    stalls = 0; reqs = 0; done = 0; be_seen = 1'b0; rwo_seen = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!stallM) begin
        done = 1; be_seen = busErrM; rwo_seen = regWriteOutM;
      end else begin
        stalls++;
        if (memReq) reqs++;
      end
      @(posedge clk); #1;
    end
    chk("timeout completed", 32'(done), 32'd1);
    chk("timeout req cycles", 32'(reqs), 32'd4);
    chk("timeout stall cycles", 32'(stalls), 32'd5);
    chk("timeout busErrM in DONE", 32'(be_seen), 32'd1);
    chk("timeout regWriteOutM", 32'(rwo_seen), 32'd0);
    bubble();
    @(negedge clk);
    chk("busErrM one cycle", 32'(busErrM), 32'd0);
    chk("timeout readDataM unchanged", readDataM, exp_last);
    @(posedge clk); #1;

`ifdef MEM_ALIGN_CHECK_EN
    validM = 1'b1; regWriteM = 1'b1; memToRegM = 1'b1; memSizeM = 2'b10; ALUOutM = 32'h0000_3001;
    @(negedge clk);
    chk("align alignErrM", 32'(alignErrM), 32'd1);
    chk("align stallM", 32'(stallM), 32'd0);
    chk("align regWriteOutM", 32'(regWriteOutM), 32'd0);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    chk("align memReq", 32'(memReq), 32'd0);
    chk("align pulse ends", 32'(alignErrM), 32'd0);
    @(posedge clk); #1;
`endif

    // Reset during the second BUSY cycle.
    validM = 1'b1; regWriteM = 1'b1; memToRegM = 1'b1; memSizeM = 2'b10; ALUOutM = 32'h0000_8000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset memReq", 32'(memReq), 32'd1);
    rstN = 1'b0; memReady = 1'b1; memRdata = 32'h5555_5555;
    @(posedge clk); #1;
    memReady = 1'b0; memRdata = 32'h0;
    @(negedge clk);
    chk("midreset memReq", 32'(memReq), 32'd0);
    chk("midreset memWe", 32'(memWe), 32'd0);
    chk("midreset stallM", 32'(stallM), 32'd0);
    chk("midreset readDataM", readDataM, 32'h0);
    @(posedge clk); #1;
    rstN = 1'b1;
    bubble();
    @(negedge clk);
    chk("post-reset idle memReq", 32'(memReq), 32'd0);
    chk("post-reset idle stallM", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    run_access('{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h80FF_FF00, 0, 32'h0000_1000, 32'h0,
                 4'b1111, 32'h0000_0080}, "after_reset_lbu");
    bubble();
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

- Memory (M) stage of the five-stage pipeline: sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts load/store requests into a request/ready transaction on the data-memory port.
- Performs byte-lane alignment and sign/zero extension, and stalls the pipeline while a transaction is outstanding.
- Produces `readDataM` and the gated `regWriteOutM` consumed by the MEM/WB register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255, maximum BUSY cycles before the access is aborted (≥1).

Ports:
- `clk`  in  1  pipeline clock; all logic rising-edge.
- `rstN`  in  1  synchronous active-low reset.
- `validM`  in  1  instruction in M is real (not a bubble).
- `regWriteM`  in  1  instruction writes the register file.
- `memToRegM`  in  1  load.
- `memWriteM`  in  1  store.
- `memSizeM`  in  2  access size: byte, half or word.
- `memSignedM`  in  1  sign-extend load result.
- `ALUOutM`  in  32  effective address.
- `writeDataM`  in  32  store data, right-justified.
- `memRdata`  in  32  memory read data, valid with `memReady`.
- `memReady`  in  1  memory completes the current request.
- `memReq`  out  1  request valid.
- `memWe`  out  1  write request.
- `memAddr`  out  32  word address, low two bits zero.
- `memWdata`  out  32  lane-replicated store data.
- `memBe`  out  4  byte enables, little-endian.
- `readDataM`  out  32  aligned and extended load data.
- `regWriteOutM`  out  1  `regWriteM` gated by error conditions.
- `stallM`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
- `busErrM`  out  1  one-cycle pulse: access timed out.
- `alignErrM`  out  1  one-cycle pulse: misaligned access; tied 0 without the macro.

## Operation
- Access = `validM & (memToRegM | memWriteM)`.
- FSM states:
  - IDLE:
    - Access seen → latch address, data, byte enables and write flag into request registers; go BUSY.
    - Otherwise stay IDLE.
  - BUSY:
    - `memReady` → capture the extracted load result into `readDataM` (loads only); go DONE.
    - Counter reaches `TIMEOUT_CYCLES` → go DONE with the error flag set.
  - DONE: always → IDLE. No new access is accepted in DONE, because the same instruction is still presented at the inputs.
- `stallM`:
  - = 1 in IDLE when an access is seen, and in every BUSY cycle.
  - = 0 in DONE and for non-access instructions.
- `memReq` and `memWe` are registered; asserted only in BUSY.
  - Both drop on the edge at which `memReady` is sampled.
  - `memAddr`, `memWdata`, `memBe` are held stable throughout BUSY.
- Stores:
  - byte: `memWdata` = byte replicated ×4; `memBe` = 1 << addr[1:0].
  - half: halfword replicated ×2; `memBe` = addr[1] ? 1100 : 0011.
  - word: data unchanged; `memBe` = 1111.
- Loads:
  - Select the lane by addr[1:0] (byte) or addr[1] (half).
  - Extend to 32 bits per `memSignedM`; word loads pass through.
- `readDataM` holds its last value for non-load instructions.
- `regWriteOutM` = `regWriteM & validM`, forced 0 during DONE of a timed-out access and for a misaligned access.
- Timeout:
  - An 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle without `memReady`.
  - On reaching `TIMEOUT_CYCLES`: `memReq` drops and `busErrM` pulses in DONE.
  - `memReady` in the same cycle as the limit → the access completes normally; no error.
- Reset values: state IDLE, `memReq`/`memWe` 0, `memAddr`/`memWdata` 0, `memBe` 0, `readDataM` 0, counter 0, `busErrM`/`alignErrM` 0.
- Reset mid-transaction abandons the access: `memReq` is 0 after the reset edge, and no result is written.

## Timing
- Zero-wait memory (`memReady` in the first BUSY cycle) takes 3 cycles:
  - cycle 0: IDLE, stall.
  - cycle 1: BUSY, `memReq`, `memReady`.
  - cycle 2: DONE, `readDataM` valid, stall low; MEM/WB captures at the end of cycle 2.
- Each wait state adds one cycle.
- Non-memory instructions pass with 0 added cycles.
- Back-to-back accesses: the second access is recognised in the IDLE cycle following DONE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned accesses are half at odd address, or word with addr[1:0] ≠ 0.
  - A misaligned access issues no request and raises no stall.
  - `alignErrM` pulses for that cycle and `regWriteOutM` = 0.
- Macro undefined:
  - No check; word accesses ignore addr[1:0] and half accesses ignore addr[0].
  - `alignErrM` is tied 0.

## Structure
- Package `mem_pkg`:
  - Size encodings SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10 (11 treated as word).
  - FSM state enum (IDLE, BUSY, DONE).
- Sub-module `load_align`: combinational lane select plus extension (rdata, addr[1:0], size, signed → 32-bit result).

## Test plan
- Load byte, signed, addr 0x1003, `memRdata` 0x80FF_FF00, `memReady` in the first BUSY cycle → `memAddr` 0x1000, `memBe` 1111 ignored for reads, `readDataM` 0xFFFF_FF80 in DONE, stall high for exactly 2 cycles.
- Store half, addr 0x2002, `writeDataM` 0x1234_ABCD, 3 wait states → `memWdata` 0xABCD_ABCD, `memBe` 1100, `memWe` high 4 cycles, stall high 5 cycles.
- Load word with `memReady` never asserted, `TIMEOUT_CYCLES`=4 → `memReq` high 4 cycles, `busErrM` pulses 1 cycle, `regWriteOutM`=0.
- `rstN` low in the second BUSY cycle → next cycle `memReq`=0, `stallM`=0, `readDataM`=0, state IDLE.
- Add instruction after load completes → no stall, `readDataM` unchanged, `regWriteOutM`=1.
- With `MEM_ALIGN_CHECK_EN`, load word at 0x3001 → no `memReq`, `alignErrM`=1 for 1 cycle, `regWriteOutM`=0, no stall.
